// File: rtl/ebpf_cpu_core.sv
// ebpf_cpu_core: single-issue eBPF core, one instruction per clock.
// Ports: clk, reset (async, active-low), instruction fetch bus, data memory bus.

module ebpfRegFile #(
  parameter logic [63:0] STACK_TOP = 64'h200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rdAddrA,
  input  logic [3:0]  rdAddrB,
  output logic [63:0] rdDataA,
  output logic [63:0] rdDataB,
  input  logic        wrEn,
  input  logic [3:0]  wrAddr,
  input  logic [63:0] wrData
);
  logic [63:0] gprs [0:10];

  // r10 is the frame pointer: only reset touches it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 10; i++) gprs[i] <= '0;
      gprs[10] <= STACK_TOP;
    end else if (wrEn && wrAddr < 4'd10) begin
      gprs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = (rdAddrA <= 4'd10) ? gprs[rdAddrA] : '0;
  assign rdDataB = (rdAddrB <= 4'd10) ? gprs[rdAddrB] : '0;
endmodule

module ebpf_cpu_core #(
  parameter logic [63:0] STACK_TOP = 64'h0000_0000_0000_0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] firstInstructionAddress,
  input  logic [63:0] instructionFromMem,
  output logic [63:0] addressForInstruction,
  input  logic [1:0]  instructionMemoryExc,
  input  logic [63:0] dataFromMem,
  output logic [63:0] addressForData,
  output logic [63:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  output logic [1:0]  sizeSelect,
  input  logic [1:0]  dataMemoryExc
);
  typedef enum logic [1:0] {RUN, IMM_HI, HALT} coreState;

  coreState    state, nextState;
  logic [63:0] pc, nextPc;
  logic [31:0] immLo;
  logic [3:0]  immDst;
  logic        latchImm;

  logic [7:0]  opcode;
  logic [3:0]  dst, src, op;
  logic [2:0]  cls;
  logic [15:0] off;
  logic [31:0] imm;
  logic [63:0] immSext, offSext, opnd;
  logic [63:0] dstVal, srcVal;
  logic [63:0] pcNext8, pcJump;

  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [63:0] wrData;

  logic        is32, isLdImm, isAlu, isExit;
  logic        isJmp, isLdx, isStore, memMode;
  logic        fetchFault, dataFault;

  logic [63:0] aluA, aluB, aluRes;
  logic [5:0]  shAmt;
  logic        aluOk, aluWb;
  logic        jTaken, jOk;
  logic [1:0]  memSize;

  assign opcode  = instructionFromMem[7:0];
  assign dst     = instructionFromMem[11:8];
  assign src     = instructionFromMem[15:12];
  assign off     = instructionFromMem[31:16];
  assign imm     = instructionFromMem[63:32];
  assign cls     = opcode[2:0];
  assign op      = opcode[7:4];
  assign immSext = {{32{imm[31]}}, imm};
  assign offSext = {{48{off[15]}}, off};
  assign opnd    = opcode[3] ? srcVal : immSext;

  assign pcNext8 = pc + 64'd8;
  assign pcJump  = pcNext8 + {offSext[60:0], 3'b000};

  assign is32    = (cls == 3'd4);
  assign memMode = (opcode[7:5] == 3'b011);
  assign isLdImm = (opcode == 8'h18);
  assign isAlu   = (cls == 3'd7) || is32;
  assign isExit  = (opcode == 8'h95);
  assign isJmp   = (cls == 3'd5) && !isExit;
  assign isLdx   = (cls == 3'd1) && memMode;
  assign isStore = (cls == 3'd2 || cls == 3'd3) && memMode;

  assign fetchFault = (instructionMemoryExc != 2'b00);
  assign dataFault  = (dataMemoryExc != 2'b00);

  assign addressForInstruction = pc;

  ebpfRegFile #(.STACK_TOP(STACK_TOP)) rFile (
    .clk    (clk),
    .reset  (reset),
    .rdAddrA(dst),
    .rdAddrB(src),
    .rdDataA(dstVal),
    .rdDataB(srcVal),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData)
  );

  always_comb begin
    aluA   = is32 ? {32'b0, dstVal[31:0]} : dstVal;
    aluB   = is32 ? {32'b0, opnd[31:0]} : opnd;
    shAmt  = is32 ? {1'b0, aluB[4:0]} : aluB[5:0];
    aluRes = '0;
    aluOk  = 1'b1;
    aluWb  = 1'b1;
    case (op)
      4'h0: aluRes = aluA + aluB;
      4'h1: aluRes = aluA - aluB;
      4'h2: aluRes = aluA * aluB;
      4'h3: aluRes = (aluB == '0) ? '0 : aluA / aluB;
      4'h4: aluRes = aluA | aluB;
      4'h5: aluRes = aluA & aluB;
      4'h6: aluRes = aluA << shAmt;
      4'h7: aluRes = aluA >> shAmt;
      4'h8: aluRes = -aluA;
      4'h9: begin
        if (aluB == '0) aluWb = 1'b0;
        else            aluRes = aluA % aluB;
      end
      4'ha: aluRes = aluA ^ aluB;
      4'hb: aluRes = aluB;
      4'hc: begin
        if (is32)
          aluRes = {32'b0,
            32'($signed(aluA[31:0]) >>> shAmt[4:0])};
        else
          aluRes = 64'($signed(aluA) >>> shAmt);
      end
      default: aluOk = 1'b0;
    endcase
    if (is32) aluRes = {32'b0, aluRes[31:0]};
  end

  always_comb begin
    jTaken = 1'b0;
    jOk    = 1'b1;
    case (op)
      4'h0: jTaken = 1'b1;
      4'h1: jTaken = dstVal == opnd;
      4'h2: jTaken = dstVal > opnd;
      4'h3: jTaken = dstVal >= opnd;
      4'h4: jTaken = (dstVal & opnd) != '0;
      4'h5: jTaken = dstVal != opnd;
      4'h6: jTaken = $signed(dstVal) > $signed(opnd);
      4'h7: jTaken = $signed(dstVal) >= $signed(opnd);
      4'ha: jTaken = dstVal < opnd;
      4'hb: jTaken = dstVal <= opnd;
      4'hc: jTaken = $signed(dstVal) < $signed(opnd);
      4'hd: jTaken = $signed(dstVal) <= $signed(opnd);
      default: jOk = 1'b0;
    endcase
  end

  // eBPF size {W,H,B,DW} -> memory size {word,half,byte,dword}
  always_comb begin
    case (opcode[4:3])
      2'b00:   memSize = 2'b10;
      2'b01:   memSize = 2'b01;
      2'b10:   memSize = 2'b00;
      default: memSize = 2'b11;
    endcase
  end

  always_comb begin
    nextState      = state;
    nextPc         = pc;
    latchImm       = 1'b0;
    wrEn           = 1'b0;
    wrAddr         = dst;
    wrData         = '0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    sizeSelect     = 2'b00;
    addressForData = '0;
    writeData      = '0;
    if (reset) begin
      case (state)
        RUN: begin
          if (fetchFault) begin
            nextState = HALT;
          end else begin
            unique case (1'b1)
              isLdImm: begin
                latchImm  = 1'b1;
                nextPc    = pcNext8;
                nextState = IMM_HI;
              end
              isAlu: begin
                if (aluOk) begin
                  wrEn   = aluWb;
                  wrData = aluRes;
                  nextPc = pcNext8;
                end else begin
                  nextState = HALT;
                end
              end
              isExit: nextState = HALT;
              isJmp: begin
                if (jOk) nextPc = jTaken ? pcJump : pcNext8;
                else     nextState = HALT;
              end
              isLdx: begin
                memRead        = 1'b1;
                sizeSelect     = memSize;
                addressForData = srcVal + offSext;
                if (dataFault) begin
                  nextState = HALT;
                end else begin
                  wrEn   = 1'b1;
                  wrData = dataFromMem;
                  nextPc = pcNext8;
                end
              end
              isStore: begin
                memWrite       = 1'b1;
                sizeSelect     = memSize;
                addressForData = dstVal + offSext;
                writeData      = cls[0] ? srcVal : immSext;
                if (dataFault) nextState = HALT;
                else           nextPc = pcNext8;
              end
              default: nextState = HALT;
            endcase
          end
        end
        IMM_HI: begin
          if (fetchFault) begin
            nextState = HALT;
          end else begin
            wrEn      = 1'b1;
            wrAddr    = immDst;
            wrData    = {imm, immLo};
            nextPc    = pcNext8;
            nextState = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      pc     <= firstInstructionAddress;
      immLo  <= '0;
      immDst <= '0;
    end else begin
      state <= nextState;
      pc    <= nextPc;
      if (latchImm) begin
        immLo  <= imm;
        immDst <= dst;
      end
    end
  end
endmodule

// File: tb/tb_ebpf_cpu_core.sv
// tb_ebpf_cpu_core: runs small eBPF programs on ebpf_cpu_core.
// Expected r0/PC per program are queued and popped when the core halts.

module tb_ebpf_cpu_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] firstInstructionAddress;
  logic [63:0] instructionFromMem;
  logic [63:0] addressForInstruction;
  logic [1:0]  instructionMemoryExc;
  logic [63:0] dataFromMem;
  logic [63:0] addressForData;
  logic [63:0] writeData;
  logic        memRead, memWrite;
  logic [1:0]  sizeSelect;
  logic [1:0]  dataMemoryExc;

  logic [63:0] imem [0:63];
  logic [7:0]  dmem [0:1023];
  logic [9:0]  ldAddr;
  logic        faultLd;
  logic [63:0] lastStAddr;
  logic [1:0]  lastStSize, lastLdSize;

  logic [63:0] prog [$];
  typedef struct packed {
    logic [63:0] r0;
    logic [63:0] pc;
  } expT;
  expT sb [$];

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  ebpf_cpu_core dut (
    .clk                    (clk),
    .reset                  (reset),
    .firstInstructionAddress(firstInstructionAddress),
    .instructionFromMem     (instructionFromMem),
    .addressForInstruction  (addressForInstruction),
    .instructionMemoryExc   (instructionMemoryExc),
    .dataFromMem            (dataFromMem),
    .addressForData         (addressForData),
    .writeData              (writeData),
    .memRead                (memRead),
    .memWrite               (memWrite),
    .sizeSelect             (sizeSelect),
    .dataMemoryExc          (dataMemoryExc)
  );

  assign instructionFromMem   = imem[addressForInstruction[8:3]];
  assign instructionMemoryExc = 2'b00;
  assign dataMemoryExc = (faultLd && memRead) ? 2'b01 : 2'b00;

  always_comb begin
    ldAddr      = addressForData[9:0];
    dataFromMem = '0;
    for (int i = 0; i < 8; i++)
      if (i < (1 << sizeSelect))
        dataFromMem[8*i +: 8] = dmem[ldAddr + 10'(i)];
  end

  always @(posedge clk) begin
    if (memWrite && dataMemoryExc == 2'b00) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << sizeSelect))
          dmem[addressForData[9:0] + 10'(i)] <= writeData[8*i +: 8];
      lastStAddr <= addressForData;
      lastStSize <= sizeSelect;
    end
    if (memRead) lastLdSize <= sizeSelect;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ins(input logic [7:0] o,
                                      input logic [3:0] d,
                                      input logic [3:0] s,
                                      input logic [15:0] f,
                                      input logic [31:0] i);
    return {i, f, s, d, o};
  endfunction

  task automatic runProg(input string tag,
                         input logic [63:0] r0,
                         input logic [63:0] pc);
    expT e;
    logic [63:0] prev;
    logic halted;
    sb.push_back('{r0: r0, pc: pc});
    @(negedge clk);
    reset = 1'b0;
    firstInstructionAddress = '0;
    for (int i = 0; i < 64; i++)
      imem[i] = (i < prog.size()) ? prog[i] : '0;
    @(negedge clk);
    reset = 1'b1;
    prev = addressForInstruction;
    halted = 1'b0;
    for (int c = 0; c < 1000 && !halted; c++) begin
      @(posedge clk);
      #1;
      if (addressForInstruction == prev) halted = 1'b1;
      prev = addressForInstruction;
    end
    chk({tag, "_halt"}, {63'b0, halted}, 64'd1);
    e = sb.pop_front();
    chk({tag, "_r0"}, dut.rFile.gprs[0], e.r0);
    chk({tag, "_pc"}, addressForInstruction, e.pc);
    prog.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    faultLd = 1'b0;
    reset = 1'b0;
    firstInstructionAddress = 64'h40;
    for (int i = 0; i < 64; i++) imem[i] = ins(8'h7a, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", addressForInstruction, 64'h40);
    chk("rst_r0", dut.rFile.gprs[0], 64'h0);
    chk("rst_r10", dut.rFile.gprs[10], 64'h200);
    chk("rst_rw", {62'b0, memRead, memWrite}, 64'h0);
    chk("rst_adr", addressForData, 64'h0);
    chk("rst_wd", writeData, 64'h0);
    chk("rst_sz", {62'b0, sizeSelect}, 64'h0);

    prog.push_back(ins(8'hb7, 0, 0, 0, 5));
    prog.push_back(ins(8'h07, 0, 0, 0, 7));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("add", 64'h0c, 64'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("add_frozen", addressForInstruction, 64'd16);

    prog.push_back(ins(8'hb7, 1, 0, 0, 32'hffff_ffff));
    prog.push_back(ins(8'hbc, 0, 1, 0, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("mov32", 64'h0000_0000_ffff_ffff, 64'd16);

    prog.push_back(ins(8'h18, 0, 0, 0, 32'h5566_7788));
    prog.push_back(ins(8'h00, 0, 0, 0, 32'h1122_3344));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("lddw", 64'h1122_3344_5566_7788, 64'd16);

    prog.push_back(ins(8'h7a, 10, 0, 16'hfff8, 32'h1234));
    prog.push_back(ins(8'h71, 0, 10, 16'hfff8, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("stld", 64'h34, 64'd16);
    chk("st_addr", lastStAddr, 64'h1f8);
    chk("st_size", {62'b0, lastStSize}, 64'd3);
    chk("ld_size", {62'b0, lastLdSize}, 64'd0);
    chk("st_byte1", {56'b0, dmem[10'h1f9]}, 64'h12);

    for (int n = 67; n <= 68; n++) begin
      prog.push_back(ins(8'hb7, 1, 0, 0, 32'(n)));
      prog.push_back(ins(8'hb7, 0, 0, 0, 1));
      prog.push_back(ins(8'hb7, 2, 0, 0, 2));
      prog.push_back(ins(8'hbf, 3, 2, 0, 0));
      prog.push_back(ins(8'h2f, 3, 2, 0, 0));
      prog.push_back(ins(8'h2d, 3, 1, 16'd6, 0));
      prog.push_back(ins(8'hbf, 4, 1, 0, 0));
      prog.push_back(ins(8'h9f, 4, 2, 0, 0));
      prog.push_back(ins(8'h15, 4, 0, 16'd2, 0));
      prog.push_back(ins(8'h07, 2, 0, 0, 1));
      prog.push_back(ins(8'h05, 0, 0, 16'hfff8, 0));
      prog.push_back(ins(8'hb7, 0, 0, 0, 0));
      prog.push_back(ins(8'h95, 0, 0, 0, 0));
      runProg(n == 67 ? "prime67" : "prime68",
              n == 67 ? 64'd1 : 64'd0, 64'd96);
    end

    prog.push_back(ins(8'hb7, 0, 0, 0, 9));
    prog.push_back(ins(8'h37, 0, 0, 0, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("div0", 64'd0, 64'd16);

    prog.push_back(ins(8'hb7, 0, 0, 0, 9));
    prog.push_back(ins(8'h97, 0, 0, 0, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("mod0", 64'd9, 64'd16);

    prog.push_back(ins(8'hb7, 1, 0, 0, 32'hffff_ffff));
    prog.push_back(ins(8'hb7, 0, 0, 0, 0));
    prog.push_back(ins(8'h65, 1, 0, 16'd1, 0));
    prog.push_back(ins(8'h07, 0, 0, 0, 1));
    prog.push_back(ins(8'h25, 1, 0, 16'd1, 0));
    prog.push_back(ins(8'h07, 0, 0, 0, 16));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("sgn", 64'd1, 64'd48);

    prog.push_back(ins(8'hb7, 0, 0, 0, 32'h8000_0000));
    prog.push_back(ins(8'hc4, 0, 0, 0, 4));
    prog.push_back(ins(8'h67, 0, 0, 0, 68));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("shift", 64'h0000_000f_8000_0000, 64'd24);

    prog.push_back(ins(8'hb7, 10, 0, 0, 5));
    prog.push_back(ins(8'hbf, 0, 10, 0, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("r10ro", 64'h200, 64'd16);

    prog.push_back(ins(8'hb7, 0, 0, 0, 3));
    prog.push_back(ins(8'hff, 0, 0, 0, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("badop", 64'd3, 64'd8);

    faultLd = 1'b1;
    prog.push_back(ins(8'hb7, 0, 0, 0, 32'h55));
    prog.push_back(ins(8'h79, 0, 10, 16'hfff8, 0));
    prog.push_back(ins(8'h95, 0, 0, 0, 0));
    runProg("dfault", 64'h55, 64'd8);
    chk("dfault_rd", {63'b0, memRead}, 64'd0);
    faultLd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
